// File: rtl/weight_read_sequencer.sv
// Weight-memory read sequencer for one neuron pass: issues ren/raddr per
// accepted input sample and tags the returned weight valid/last for the MAC.
module weight_read_sequencer #(
    parameter int NUM_WEIGHT = 784,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ren,
    output logic [ADDR_WIDTH:0]   raddr,
    output logic                  w_valid,
    output logic                  w_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(NUM_WEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] raddr_nxt;
    logic                at_last;

    assign at_last = (raddr == LAST);

    always_comb begin
        state_nxt = state;
        raddr_nxt = raddr;
        in_ready  = 1'b0;
        ren       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    raddr_nxt = '0;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                ren      = in_valid;
                if (in_valid) begin
                    // Hold on the final address so raddr never leaves range
                    if (at_last) state_nxt = DRAIN;
                    else         raddr_nxt = raddr + 1'b1;
                end
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                state_nxt = IDLE;
                raddr_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            raddr_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            raddr   <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else begin
            state   <= state_nxt;
            raddr   <= raddr_nxt;
            // Tags line up with the memory's registered output
            w_valid <= ren & ~abort;
            w_last  <= ren & ~abort & at_last;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_weight_read_sequencer.sv
// Directed bench for weight_read_sequencer (NUM_WEIGHT=4 and NUM_WEIGHT=1)
// with a registered-read weight memory model holding mem[i]=i+10.
module tb_weight_read_sequencer;

    logic       clk;
    logic       rst;
    logic       start, abort, in_valid;
    logic       in_ready, ren, w_valid, w_last, busy, done;
    logic [2:0] raddr;
    logic [7:0] wout;

    logic       start1, abort1, in_valid1;
    logic       in_ready1, ren1, w_valid1, w_last1, busy1, done1;
    logic [2:0] raddr1;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int wv_count;
    logic [6:0] pat;

    weight_read_sequencer #(.NUM_WEIGHT(4), .ADDR_WIDTH(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .ren(ren),
        .raddr(raddr), .w_valid(w_valid), .w_last(w_last),
        .busy(busy), .done(done)
    );

    weight_read_sequencer #(.NUM_WEIGHT(1), .ADDR_WIDTH(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .in_valid(in_valid1), .in_ready(in_ready1), .ren(ren1),
        .raddr(raddr1), .w_valid(w_valid1), .w_last(w_last1),
        .busy(busy1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered-read memory model: mem[i] = i + 10
    always @(posedge clk) begin
        if (ren) wout <= 8'(raddr) + 8'd10;
    end

    always @(posedge clk) begin
        if (done) done_count = done_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; abort = 0; in_valid = 0;
        start1 = 0; abort1 = 0; in_valid1 = 0;

        // 1: reset and idle
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ren", ren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_done", done, 0);
        tick;
        rst = 1'b0;
        in_valid = 1;
        mid;
        chk("idle_in_ready", in_ready, 0);
        chk("idle_ren", ren, 0);
        tick;
        mid;
        chk("idle_w_valid", w_valid, 0);
        chk("idle_raddr", raddr, 0);
        tick;

        // 2: full pass with no bubbles
        start = 1; in_valid = 0;
        mid;
        chk("p2_busy_at_start", busy, 0);
        tick;
        start = 0; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            mid;
            chk("p2_busy", busy, 1);
            chk("p2_ren", ren, 1);
            chk("p2_raddr", raddr, 32'(i));
            if (i > 0) begin
                chk("p2_w_valid", w_valid, 1);
                chk("p2_wout", wout, 32'(i + 9));
                chk("p2_w_last", w_last, 0);
            end
            tick;
        end
        in_valid = 0;
        mid;
        chk("p2_drain_w_valid", w_valid, 1);
        chk("p2_drain_wout", wout, 13);
        chk("p2_drain_w_last", w_last, 1);
        chk("p2_drain_ren", ren, 0);
        chk("p2_drain_done", done, 0);
        tick;
        mid;
        chk("p2_done", done, 1);
        chk("p2_done_w_valid", w_valid, 0);
        chk("p2_done_busy", busy, 1);
        tick;
        mid;
        chk("p2_idle_busy", busy, 0);
        chk("p2_idle_done", done, 0);
        chk("p2_idle_raddr", raddr, 0);
        tick;

        // 3: bubbles in the input stream
        pat = 7'b1011001;
        wv_count = 0;
        start = 1;
        tick;
        start = 0;
        for (int j = 0; j < 7; j++) begin
            in_valid = pat[j];
            mid;
            if (w_valid) wv_count++;
            case (j)
                0: chk("p3_raddr0", raddr, 0);
                3: chk("p3_raddr3", raddr, 1);
                4: chk("p3_raddr4", raddr, 2);
                6: chk("p3_raddr6", raddr, 3);
                default: chk("p3_hold", raddr, (j == 5) ? 3 : 1);
            endcase
            tick;
        end
        in_valid = 0;
        mid;
        if (w_valid) wv_count++;
        chk("p3_last_w_last", w_last, 1);
        chk("p3_last_wout", wout, 13);
        chk("p3_wv_count", wv_count, 4);
        tick;
        mid;
        chk("p3_done", done, 1);
        tick;
        tick;

        // 4: abort mid-pass, then restart from address 0
        start = 1;
        tick;
        start = 0; in_valid = 1;
        tick;
        tick;
        abort = 1;
        mid;
        chk("p4_abort_raddr", raddr, 2);
        chk("p4_abort_ren", ren, 1);
        tick;
        abort = 0; in_valid = 0;
        mid;
        chk("p4_busy", busy, 0);
        chk("p4_w_valid", w_valid, 0);
        chk("p4_raddr", raddr, 0);
        chk("p4_done", done, 0);
        tick;
        mid;
        chk("p4_no_done", done, 0);
        start = 1;
        tick;
        start = 0; in_valid = 1;
        mid;
        chk("p4_restart_raddr", raddr, 0);
        chk("p4_restart_ren", ren, 1);
        tick;
        in_valid = 0;
        mid;
        chk("p4_restart_wout", wout, 10);
        chk("p4_restart_w_valid", w_valid, 1);
        abort = 1;
        tick;
        abort = 0;

        // 5: async reset between edges, then start while busy
        start = 1;
        tick;
        start = 0; in_valid = 1;
        tick;
        mid;
        chk("p5_pre_raddr", raddr, 1);
        #2;
        rst = 1;
        #1;
        chk("p5_rst_busy", busy, 0);
        chk("p5_rst_raddr", raddr, 0);
        chk("p5_rst_w_valid", w_valid, 0);
        chk("p5_rst_ren", ren, 0);
        chk("p5_rst_in_ready", in_ready, 0);
        in_valid = 0;
        rst = 0;
        tick;
        begin
            int dc0;
            dc0 = done_count;
            start = 1;
            tick;
            start = 0; in_valid = 1;
            mid;
            chk("p5_raddr0", raddr, 0);
            tick;
            start = 1;
            mid;
            chk("p5_busy_start_raddr", raddr, 1);
            tick;
            start = 0;
            mid;
            chk("p5_ignored_raddr", raddr, 2);
            tick;
            tick;
            in_valid = 0;
            tick;
            tick;
            mid;
            chk("p5_idle", busy, 0);
            chk("p5_pass_count", done_count, 32'(dc0 + 1));
        end
        tick;

        // 6: single-weight build
        start1 = 1;
        tick;
        start1 = 0; in_valid1 = 1;
        mid;
        chk("p6_ren", ren1, 1);
        chk("p6_raddr", raddr1, 0);
        tick;
        in_valid1 = 0;
        mid;
        chk("p6_w_valid", w_valid1, 1);
        chk("p6_w_last", w_last1, 1);
        chk("p6_no_done_yet", done1, 0);
        tick;
        mid;
        chk("p6_done", done1, 1);
        chk("p6_w_valid_off", w_valid1, 0);
        tick;
        mid;
        chk("p6_idle", busy1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
